// File: rtl/q2_pkg.sv
// Shared constants and types for the q2 memory arbiter: bus width, default
// output-port address and the access FSM state encoding.
package q2_pkg;

    localparam int BUS_W = 12;
    localparam int CNT_W = 4;

    localparam logic [BUS_W-1:0] DEFAULT_OUT_ADDR = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/q2_rr_arb2.sv
// Two-way round-robin arbiter between the CPU and console ports; the
// last-grant flop resets to CPU so the console wins the first tie.
module q2_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_cpu,
    input  logic req_con,
    input  logic accept,
    output logic gnt_valid,
    output logic gnt_con
);

    logic last_con;

    always_comb begin
        gnt_valid = req_cpu | req_con;
        gnt_con   = req_con & (~req_cpu | ~last_con);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_con <= 1'b0;
        end else if (accept) begin
            last_con <= gnt_con;
        end
    end

endmodule

// File: rtl/q2_mem_arb.sv
// Shared-RAM arbiter for CPU and console ports: SETUP / STROBE / HOLD bus
// cycle with a programmable strobe width and a memory-mapped output port.
//
//   state  | meaning
//   IDLE   | waiting for a request, arbitrates and latches the winner
//   SETUP  | address (and write data) driven, no strobe
//   STROBE | wrm or rdm asserted for WAIT_CYCLES clocks, read data sampled last cycle
//   HOLD   | strobes low, bus held, winner acked, output port updated
module q2_mem_arb
    import q2_pkg::*;
#(
    parameter int               WAIT_CYCLES = 1,
    parameter logic [BUS_W-1:0] OUT_ADDR    = DEFAULT_OUT_ADDR
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [BUS_W-1:0] cpu_addr,
    input  logic [BUS_W-1:0] cpu_wdata,
    output logic             cpu_ack,
    output logic [BUS_W-1:0] cpu_rdata,

    input  logic             con_req,
    input  logic             con_we,
    input  logic [BUS_W-1:0] con_addr,
    input  logic [BUS_W-1:0] con_wdata,
    output logic             con_ack,
    output logic [BUS_W-1:0] con_rdata,

    output logic [BUS_W-1:0] abus,
    output logic [BUS_W-1:0] dbus_out,
    output logic             dbus_oe,
    input  logic [BUS_W-1:0] dbus_in,
    output logic             wrm,
    output logic             rdm,

    output logic [BUS_W-1:0] out_data,
    output logic             out_valid
);

    localparam logic [CNT_W-1:0] WAIT_M1 = CNT_W'(WAIT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             rst_q;
    logic             rst_n_int;
    logic             gnt_valid;
    logic             gnt_con;
    logic             accept;
    logic             lat_con;
    logic             lat_we;
    logic [BUS_W-1:0] lat_addr;
    logic [BUS_W-1:0] lat_wdata;
    logic [CNT_W-1:0] cnt;
    logic             strobe_last;
    logic             is_out;

    // Assertion is immediate; release takes one clk so the first arbitration
    // lands on the second rising edge after rst goes high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_q <= 1'b0;
        end else begin
            rst_q <= 1'b1;
        end
    end

    assign rst_n_int = rst_q;

    q2_rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n_int),
        .req_cpu   (cpu_req),
        .req_con   (con_req),
        .accept    (accept),
        .gnt_valid (gnt_valid),
        .gnt_con   (gnt_con)
    );

    assign accept      = (state == IDLE) && gnt_valid;
    assign strobe_last = (state == STROBE) && (cnt == '0);
    assign is_out      = (lat_addr == OUT_ADDR);

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (cnt == '0) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wrm       = 1'b0;
        rdm       = 1'b0;
        dbus_oe   = 1'b0;
        cpu_ack   = 1'b0;
        con_ack   = 1'b0;
        out_valid = 1'b0;
        case (state)
            SETUP: begin
                dbus_oe = lat_we;
            end
            STROBE: begin
                dbus_oe = lat_we;
                wrm     = lat_we;
                rdm     = ~lat_we;
            end
            HOLD: begin
                dbus_oe   = lat_we;
                cpu_ack   = ~lat_con;
                con_ack   = lat_con;
                out_valid = lat_we & is_out;
            end
            default: ;
        endcase
    end

    assign abus     = lat_addr;
    assign dbus_out = lat_wdata;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            lat_con   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_con   <= gnt_con;
            lat_we    <= gnt_con ? con_we    : cpu_we;
            lat_addr  <= gnt_con ? con_addr  : cpu_addr;
            lat_wdata <= gnt_con ? con_wdata : cpu_wdata;
        end
    end

    // Strobe timer: loaded on SETUP exit, counts down to zero and stops.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            cnt <= '0;
        end else if (state == SETUP) begin
            cnt <= WAIT_M1;
        end else if ((state == STROBE) && (cnt != '0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            cpu_rdata <= '0;
            con_rdata <= '0;
        end else if (strobe_last && !lat_we) begin
            if (lat_con) begin
                con_rdata <= dbus_in;
            end else begin
                cpu_rdata <= dbus_in;
            end
        end
    end

    // Loaded on entry to HOLD so out_data is already valid alongside out_valid.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            out_data <= '0;
        end else if (strobe_last && lat_we && is_out) begin
            out_data <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_q2_mem_arb.sv
// Directed bench for q2_mem_arb: a RAM model on the shared bus, a WAIT_CYCLES=1
// instance for the main sequences and a WAIT_CYCLES=3 instance for strobe width.
module tb_q2_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0, cpu_wdata = '0;
    logic        con_req = 1'b0, con_we = 1'b0;
    logic [11:0] con_addr = '0, con_wdata = '0;
    logic        cpu_ack, con_ack, dbus_oe, wrm, rdm, out_valid;
    logic [11:0] cpu_rdata, con_rdata, abus, dbus_out, dbus_in, out_data;

    logic        x_req = 1'b0, x_we = 1'b0;
    logic [11:0] x_addr = '0, x_wdata = '0, x_in = 12'h3C9;
    logic        x_con_req = 1'b0, x_con_we = 1'b0;
    logic [11:0] x_con_addr = '0, x_con_wdata = '0;
    logic        x_cpu_ack, x_con_ack, x_oe, x_wrm, x_rdm, x_ov;
    logic [11:0] x_cpu_rdata, x_con_rdata, x_abus, x_dout, x_od;

    logic [11:0] ram [0:4095];
    int          checks = 0;
    int          failures = 0;
    int          viol = 0;

    int          ack_cyc;
    logic [15:0] wrm_mask, rdm_mask;
    int          ov_cnt;
    logic        oe_seen;
    logic [11:0] rdata_ack;

    always #5 clk = ~clk;

    q2_mem_arb #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .con_req(con_req), .con_we(con_we), .con_addr(con_addr), .con_wdata(con_wdata),
        .con_ack(con_ack), .con_rdata(con_rdata),
        .abus(abus), .dbus_out(dbus_out), .dbus_oe(dbus_oe), .dbus_in(dbus_in),
        .wrm(wrm), .rdm(rdm), .out_data(out_data), .out_valid(out_valid)
    );

    q2_mem_arb #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(x_req), .cpu_we(x_we), .cpu_addr(x_addr), .cpu_wdata(x_wdata),
        .cpu_ack(x_cpu_ack), .cpu_rdata(x_cpu_rdata),
        .con_req(x_con_req), .con_we(x_con_we), .con_addr(x_con_addr), .con_wdata(x_con_wdata),
        .con_ack(x_con_ack), .con_rdata(x_con_rdata),
        .abus(x_abus), .dbus_out(x_dout), .dbus_oe(x_oe), .dbus_in(x_in),
        .wrm(x_wrm), .rdm(x_rdm), .out_data(x_od), .out_valid(x_ov)
    );

    assign dbus_in = ram[abus];

    // RAM model: preset contents, then capture writes mid-strobe.
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 12'(i) ^ 12'h5A5;
        forever begin
            @(negedge clk);
            if (wrm) ram[abus] = dbus_out;
        end
    end

    always @(negedge clk) begin
        if ((wrm && rdm) || (rdm && dbus_oe) || (cpu_ack && con_ack)) viol++;
        if ((x_wrm && x_rdm) || (x_rdm && x_oe) || (x_cpu_ack && x_con_ack)) viol++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One access on the WAIT_CYCLES=1 instance; cycle 0 is the first IDLE cycle with req.
    task automatic access(input logic con, input logic we, input logic [11:0] a, input logic [11:0] d);
        @(posedge clk); #1;
        if (con) begin
            con_req = 1'b1; con_we = we; con_addr = a; con_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
        ack_cyc = -1; wrm_mask = '0; rdm_mask = '0; ov_cnt = 0; oe_seen = 1'b0; rdata_ack = '0;
        for (int c = 0; c < 16 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (wrm) wrm_mask[c] = 1'b1;
            if (rdm) rdm_mask[c] = 1'b1;
            if (dbus_oe) oe_seen = 1'b1;
            if (out_valid) ov_cnt++;
            if (con ? con_ack : cpu_ack) begin
                ack_cyc = c;
                rdata_ack = con ? con_rdata : cpu_rdata;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; con_req = 1'b0;
    endtask

    initial begin
        int          n;
        int          both;
        int          ack_at [4];
        logic        ack_who [4];
        int          x_ack;
        logic [15:0] x_mask;
        logic [11:0] x_rd;

        // Reset with both requesters already asking for reads.
        #3 rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
        con_req = 1'b1; con_we = 1'b0; con_addr = 12'h100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_wrm", wrm, 0);
        check_eq("rst_rdm", rdm, 0);
        check_eq("rst_oe", dbus_oe, 0);
        check_eq("rst_abus", abus, 0);
        check_eq("rst_dbus_out", dbus_out, 0);
        check_eq("rst_acks", {cpu_ack, con_ack}, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_rdata", {cpu_rdata, con_rdata}, 0);

        // Tie after release: console, cpu, console, cpu, acks every 4 cycles.
        @(posedge clk); #1;
        rst = 1'b1;
        n = 0; both = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (cpu_ack && con_ack) both++;
            if (con_ack) begin
                ack_who[n] = 1'b1; ack_at[n] = c; n++;
            end else if (cpu_ack) begin
                ack_who[n] = 1'b0; ack_at[n] = c; n++;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; con_req = 1'b0;
        check_eq("tie_grants", n, 4);
        check_eq("tie_both_acks", both, 0);
        check_eq("tie_who0", ack_who[0], 1);
        check_eq("tie_who1", ack_who[1], 0);
        check_eq("tie_who2", ack_who[2], 1);
        check_eq("tie_who3", ack_who[3], 0);
        check_eq("tie_first_ack", ack_at[0], 4);
        check_eq("tie_spacing", ack_at[1] - ack_at[0], 4);
        check_eq("tie_last_ack", ack_at[3], 16);
        check_eq("tie_con_rdata", con_rdata, 12'h4A5);
        check_eq("tie_cpu_rdata", cpu_rdata, 12'h7A5);

        // CPU write 0x123 -> 0x010.
        access(1'b0, 1'b1, 12'h010, 12'h123);
        check_eq("wr_wrm_mask", wrm_mask, 16'b100);
        check_eq("wr_rdm_mask", rdm_mask, 16'b0);
        check_eq("wr_ack_cyc", ack_cyc, 3);
        check_eq("wr_ram", ram[12'h010], 12'h123);
        check_eq("wr_no_out_valid", ov_cnt, 0);
        check_eq("wr_cpu_rdata_kept", cpu_rdata, 12'h7A5);

        // Console read back.
        access(1'b1, 1'b0, 12'h010, 12'h000);
        check_eq("rd_rdm_mask", rdm_mask, 16'b100);
        check_eq("rd_wrm_mask", wrm_mask, 16'b0);
        check_eq("rd_ack_cyc", ack_cyc, 3);
        check_eq("rd_rdata", rdata_ack, 12'h123);
        check_eq("rd_no_oe", oe_seen, 0);

        // Output-port write.
        access(1'b0, 1'b1, 12'hFFF, 12'h07F);
        check_eq("op_out_valid", ov_cnt, 1);
        check_eq("op_out_data", out_data, 12'h07F);
        check_eq("op_ram", ram[12'hFFF], 12'h07F);
        check_eq("op_ack_cyc", ack_cyc, 3);

        // Reading the output-port address is a plain RAM read.
        access(1'b1, 1'b0, 12'hFFF, 12'h000);
        check_eq("opr_rdata", rdata_ack, 12'h07F);
        check_eq("opr_no_out_valid", ov_cnt, 0);

        // Console write, CPU read of it.
        access(1'b1, 1'b1, 12'h030, 12'hABC);
        check_eq("cw_ram", ram[12'h030], 12'hABC);
        access(1'b0, 1'b0, 12'h030, 12'h000);
        check_eq("cr_rdata", rdata_ack, 12'hABC);
        check_eq("cr_con_rdata_kept", con_rdata, 12'h07F);

        // Reset in the middle of a write strobe.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h040; cpu_wdata = 12'h321;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("ab_wrm_before", wrm, 1);
        rst = 1'b0;
        #1;
        check_eq("ab_wrm_after", wrm, 0);
        check_eq("ab_oe_after", dbus_oe, 0);
        check_eq("ab_ack", cpu_ack, 0);
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("ab_ram_untouched", ram[12'h040], 12'h5E5);
        check_eq("ab_out_data", out_data, 0);
        check_eq("ab_rdata", {cpu_rdata, con_rdata}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        access(1'b0, 1'b1, 12'h040, 12'h321);
        check_eq("ab_retry_ack", ack_cyc, 3);
        check_eq("ab_retry_ram", ram[12'h040], 12'h321);

        // WAIT_CYCLES=3 read.
        @(posedge clk); #1;
        x_req = 1'b1; x_we = 1'b0; x_addr = 12'h055;
        x_ack = -1; x_mask = '0; x_rd = '0;
        for (int c = 0; c < 20 && x_ack < 0; c++) begin
            @(negedge clk);
            if (x_rdm) x_mask[c] = 1'b1;
            if (x_cpu_ack) begin
                x_ack = c; x_rd = x_cpu_rdata;
            end
        end
        @(posedge clk); #1;
        x_req = 1'b0;
        check_eq("w3_rdm_mask", x_mask, 16'b11100);
        check_eq("w3_ack_cyc", x_ack, 5);
        check_eq("w3_rdata", x_rd, 12'h3C9);

        repeat (2) @(posedge clk);
        check_eq("bus_rule_violations", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/q2_mem_arb.md
Q2_MEM_ARB -- requirements
Module: q2_mem_arb

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, strobe width in clocks (legal 1..15).
REQ-002 SHALL have parameter OUT_ADDR, default 12'hFFF, memory-mapped output port address.
REQ-003 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: cpu_req  in  1; cpu_we  in  1; cpu_addr  in  12; cpu_wdata  in  12; cpu_ack  out  1; cpu_rdata  out  12.
REQ-006 SHALL have ports: con_req  in  1; con_we  in  1; con_addr  in  12; con_wdata  in  12; con_ack  out  1; con_rdata  out  12 (console/panel deposit-examine port).
REQ-007 SHALL have ports: abus  out  12; dbus_out  out  12; dbus_oe  out  1; dbus_in  in  12; wrm  out  1; rdm  out  1 (shared RAM bus).
REQ-008 SHALL have ports: out_data  out  12; out_valid  out  1 (output-port capture).

Function
REQ-009 Requesters SHALL hold req, we, addr, wdata stable until their ack; ack is a single-cycle pulse.
REQ-010 FSM states SHALL be IDLE, SETUP, STROBE, HOLD.
REQ-011 IDLE: if any req, latch winner's we/addr/wdata, go SETUP; else stay.
REQ-012 Arbitration SHALL be round-robin: both requesting -> grant the port not granted last; single requester always wins.
REQ-013 SETUP (1 cycle): abus = latched addr; writes assert dbus_oe with dbus_out = wdata; wrm = rdm = 0.
REQ-014 STROBE (WAIT_CYCLES cycles): write asserts wrm, read asserts rdm; abus/dbus held.
REQ-015 Read data SHALL be sampled from dbus_in on the last STROBE cycle into the winner's rdata register.
REQ-016 HOLD (1 cycle): wrm = rdm = 0, abus/dbus_out held, dbus_oe remains asserted for writes; winner's ack = 1; next state IDLE.
REQ-017 Access latency: req seen in IDLE at cycle 0 -> ack at cycle 2+WAIT_CYCLES; minimum spacing between grants 3+WAIT_CYCLES.
REQ-018 wrm and rdm SHALL never be high together; dbus_oe SHALL be 0 whenever rdm = 1.
REQ-019 rdata registers SHALL hold value until that port's next read completes; writes do not alter them.
REQ-020 A write whose addr equals OUT_ADDR SHALL, in HOLD, load out_data = wdata and pulse out_valid one cycle; the RAM write still occurs.
REQ-021 Reads of OUT_ADDR SHALL be ordinary RAM reads.
REQ-022 A req dropped before ack is a protocol violation; behaviour unspecified, FSM SHALL still return to IDLE.
REQ-023 Counter for STROBE SHALL be 4 bits, reloaded on SETUP exit, no wrap.

Reset
REQ-024 rst low SHALL immediately force: state IDLE, wrm = rdm = dbus_oe = 0, abus = 0, dbus_out = 0, acks = 0, out_valid = 0, out_data = 0, cpu_rdata = con_rdata = 0, last-grant = CPU (console wins first tie).
REQ-025 Reset mid-access SHALL abort it with no ack, no out_valid.
REQ-026 Reset release SHALL be synchronized; first arbitration occurs on the second clk rising edge after rst high.

Structure
REQ-027 Shared package q2_pkg SHALL hold state encoding constants, bus width (12) and default OUT_ADDR.
REQ-028 One sub-module q2_rr_arb2 (2-way round-robin, last-grant flop) SHALL implement REQ-012; rest flat.

Verification
REQ-029 CPU write 0x123 to 0x010, WAIT_CYCLES = 1 -> wrm high exactly cycle 2, cpu_ack cycle 3, RAM[0x010] = 0x123, no out_valid.
REQ-030 Console read of 0x010 after REQ-029 -> rdm one cycle, con_rdata = 0x123 at con_ack, dbus_oe 0 throughout.
REQ-031 cpu_req and con_req raised same cycle after reset, held -> grant order console, CPU, console, CPU; no cycle with both acks.
REQ-032 CPU write 0x07F to 0xFFF -> out_valid one pulse, out_data = 0x07F, RAM[0xFFF] = 0x07F.
REQ-033 WAIT_CYCLES = 3, read -> rdm high 3 consecutive cycles, ack at cycle 5.
REQ-034 rst low during STROBE of a write -> wrm drops asynchronously, no ack; after release next request completes normally.
